// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - sequenced square-wave tone player driven from a small note RAM
module tone_sequencer #(
    parameter int DEPTH     = 16,
    parameter int HP_W      = 16,
    parameter int DUR_W     = 8,
    parameter int TICK_DIV  = 500_000,
    parameter int GAP_TICKS = 1,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [HP_W-1:0]  wr_hp,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic             mute,
    output logic             signal,
    output logic             busy,
    output logic [AW-1:0]    note_idx,
    output logic             done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [AW-1:0]    IDX_LAST  = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_NEXT,
        S_END
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [HP_W-1:0]  r_mem_hp  [DEPTH];
    logic [DUR_W-1:0] r_mem_dur [DEPTH];

    logic [AW-1:0]    r_note_idx;
    logic [HP_W-1:0]  r_hp;
    logic [DUR_W-1:0] r_dur;
    logic [HP_W-1:0]  r_tone_cnt;
    logic             r_tone;
    logic [PW-1:0]    r_presc;
    logic [DUR_W-1:0] r_tick_cnt;

    logic [DUR_W-1:0] w_rd_dur;
    logic             w_abort;
    logic             w_tick_wrap;
    logic             w_play_end;
    logic             w_gap_end;

    // Note RAM: no reset, written any time; LOAD takes a private copy.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem_hp[wr_addr]  <= wr_hp;
            r_mem_dur[wr_addr] <= wr_dur;
        end
    end

    assign w_rd_dur    = r_mem_dur[r_note_idx];
    assign w_abort     = stop && (r_state != S_IDLE);
    assign w_tick_wrap = (r_presc == TICK_LAST);
    assign w_play_end  = (r_state == S_PLAY) && w_tick_wrap && (r_tick_cnt == r_dur - 1'b1);
    assign w_gap_end   = (r_state == S_GAP) && w_tick_wrap && (r_tick_cnt == GAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start && !stop) w_next = S_LOAD;
                S_LOAD: w_next = (w_rd_dur == '0) ? S_END : S_PLAY;
                S_PLAY: if (w_play_end) w_next = (GAP_TICKS == 0) ? S_NEXT : S_GAP;
                S_GAP:  if (w_gap_end) w_next = S_NEXT;
                S_NEXT: w_next = (r_note_idx == IDX_LAST) ? S_END : S_LOAD;
                S_END:  w_next = loop ? S_LOAD : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_END) && !loop && !stop;
        signal   = r_tone & ~mute;
        note_idx = r_note_idx;
    end

    // Datapath: note index, latched entry, prescaler, tick and tone counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_note_idx <= '0;
            r_hp       <= '0;
            r_dur      <= '0;
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
            r_presc    <= '0;
            r_tick_cnt <= '0;
        end else if (w_abort) begin
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
            r_presc    <= '0;
            r_tick_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) r_note_idx <= '0;
                end
                S_LOAD: begin
                    r_hp       <= r_mem_hp[r_note_idx];
                    r_dur      <= w_rd_dur;
                    r_tone_cnt <= '0;
                    r_tone     <= 1'b0;
                    r_presc    <= '0;
                    r_tick_cnt <= '0;
                end
                S_PLAY: begin
                    if (r_hp != '0) begin
                        if (r_tone_cnt == r_hp - 1'b1) begin
                            r_tone_cnt <= '0;
                            r_tone     <= ~r_tone;
                        end else begin
                            r_tone_cnt <= r_tone_cnt + 1'b1;
                        end
                    end
                    if (w_tick_wrap) begin
                        r_presc    <= '0;
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                    // Leaving PLAY: silence the tone and rearm counters for the gap.
                    if (w_play_end) begin
                        r_tone_cnt <= '0;
                        r_tone     <= 1'b0;
                        r_presc    <= '0;
                        r_tick_cnt <= '0;
                    end
                end
                S_GAP: begin
                    if (w_tick_wrap) begin
                        r_presc    <= '0;
                        r_tick_cnt <= w_gap_end ? '0 : r_tick_cnt + 1'b1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (r_note_idx != IDX_LAST) r_note_idx <= r_note_idx + 1'b1;
                end
                S_END: begin
                    if (loop) r_note_idx <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - randomized self-checking bench for tone_sequencer
module tb_tone_sequencer;

    localparam int DEPTH = 4;
    localparam int HP_W  = 16;
    localparam int DUR_W = 8;
    localparam int TD    = 4;
    localparam int GT    = 1;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [HP_W-1:0]  wr_hp = '0;
    logic [DUR_W-1:0] wr_dur = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop = 1'b0;
    logic             mute = 1'b0;
    logic             signal;
    logic             busy;
    logic [AW-1:0]    note_idx;
    logic             done;

    int n_chk = 0;
    int n_err = 0;

    int m_hp  [DEPTH];
    int m_dur [DEPTH];

    int e_busy[$];
    int e_tone[$];
    int e_idx[$];
    int e_done[$];

    tone_sequencer #(
        .DEPTH(DEPTH), .HP_W(HP_W), .DUR_W(DUR_W), .TICK_DIV(TD), .GAP_TICKS(GT)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_hp(wr_hp),
        .wr_dur(wr_dur), .start(start), .stop(stop), .loop(loop), .mute(mute),
        .signal(signal), .busy(busy), .note_idx(note_idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_entry(input int a, input int hp, input int dur);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_hp   = HP_W'(hp);
        wr_dur  = DUR_W'(dur);
        step();
        wr_en   = 1'b0;
        m_hp[a]  = hp;
        m_dur[a] = dur;
    endtask

    task automatic push(input int b, input int t, input int i, input int d);
        e_busy.push_back(b);
        e_tone.push_back(t);
        e_idx.push_back(i);
        e_done.push_back(d);
    endtask

    // Expected per-cycle trace from the note table: LOAD, PLAY, GAP, NEXT, END.
    task automatic build(input bit lp, input int limit);
        int i;
        e_busy.delete(); e_tone.delete(); e_idx.delete(); e_done.delete();
        i = 0;
        while (e_busy.size() < limit) begin
            push(1, 0, i, 0);
            if (m_dur[i] == 0) begin
                push(1, 0, i, lp ? 0 : 1);
                if (lp) begin i = 0; continue; end
                break;
            end
            for (int k = 0; k < m_dur[i] * TD; k++)
                push(1, (m_hp[i] == 0) ? 0 : ((k / m_hp[i]) % 2), i, 0);
            for (int k = 0; k < GT * TD; k++)
                push(1, 0, i, 0);
            push(1, 0, i, 0);
            if (i == DEPTH - 1) begin
                push(1, 0, i, lp ? 0 : 1);
                if (lp) begin i = 0; continue; end
                break;
            end
            i++;
        end
        if (!lp) repeat (2) push(0, 0, i, 0);
    endtask

    task automatic run(input bit lp, input int limit, input int stop_at, input bit rnd_mute,
                       input int wr_at, input int wa, input int whp, input int wdur);
        build(lp, limit);
        loop  = lp;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < e_busy.size() && k < limit; k++) begin
            check($sformatf("busy@%0d", k), busy, e_busy[k]);
            check($sformatf("idx@%0d", k), note_idx, e_idx[k]);
            check($sformatf("done@%0d", k), done, e_done[k]);
            check($sformatf("signal@%0d", k), signal, (e_tone[k] != 0 && !mute) ? 1 : 0);
            if (k == stop_at) begin
                stop = 1'b1;
                step();
                stop = 1'b0;
                check("stop_busy", busy, 0);
                check("stop_signal", signal, 0);
                check("stop_done", done, 0);
                check("stop_idx", note_idx, e_idx[k]);
                break;
            end
            if (rnd_mute && $urandom_range(0, 3) == 0) mute = ~mute;
            if (k == wr_at) begin
                wr_en   = 1'b1;
                wr_addr = AW'(wa);
                wr_hp   = HP_W'(whp);
                wr_dur  = DUR_W'(wdur);
            end
            step();
            wr_en = 1'b0;
        end
        if (wr_at >= 0) begin
            m_hp[wa]  = whp;
            m_dur[wa] = wdur;
        end
        mute = 1'b0;
        loop = 1'b0;
        step();
    endtask

    initial begin
        #3;
        check("rst_busy", busy, 0);
        check("rst_signal", signal, 0);
        check("rst_done", done, 0);
        check("rst_idx", note_idx, 0);
        #10;
        rst = 1'b0;
        step();

        // Basic note
        wr_entry(0, 3, 2);
        wr_entry(1, 0, 0);
        wr_entry(2, 0, 0);
        wr_entry(3, 0, 0);
        run(0, 200, -1, 0, -1, 0, 0, 0);

        // Rest and loop, then stop to leave looping
        wr_entry(0, 0, 1);
        wr_entry(1, 2, 1);
        wr_entry(2, 0, 0);
        run(1, 60, 55, 0, -1, 0, 0, 0);

        // Stop several cycles into PLAY
        wr_entry(0, 3, 3);
        run(0, 200, 6, 0, -1, 0, 0, 0);

        // start and stop together while idle
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("collide_busy0", busy, 0);
        step();
        check("collide_busy1", busy, 0);

        // Mute toggled at random during tones
        wr_entry(0, 2, 3);
        wr_entry(1, 1, 2);
        wr_entry(2, 0, 0);
        run(0, 200, -1, 1, -1, 0, 0, 0);

        // Asynchronous reset mid-PLAY of entry 1
        wr_entry(0, 1, 1);
        wr_entry(1, 1, 3);
        wr_entry(2, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (13) step();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_idx", note_idx, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_signal", signal, 0);
        check("arst_idx", note_idx, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_busy", busy, 0);

        // Full table with a write to entry 0 while it plays, then restart
        wr_entry(0, 1, 1);
        wr_entry(1, 2, 1);
        wr_entry(2, 3, 1);
        wr_entry(3, 4, 1);
        run(0, 200, -1, 0, 3, 0, 5, 2);
        run(0, 200, -1, 0, -1, 0, 0, 0);

        // Randomized tables
        for (int r = 0; r < 8; r++) begin
            bit lp;
            int sa;
            for (int a = 0; a < DEPTH; a++)
                wr_entry(a, $urandom_range(0, 4),
                         ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3));
            lp = ($urandom_range(0, 1) == 1);
            if (lp) sa = $urandom_range(3, 140);
            else    sa = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 40) : -1;
            run(lp, 150, sa, $urandom_range(0, 1) == 1, -1, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
